pll_lock_supervisor: RTL

Sequences reset for the fabric PLL and consumes its lock indication on the other end of the PLL reset/locked interface. Drives the PLL reset pulse and synchronizes the asynchronous locked input. Waits for lock with a timeout and bounded retries, then holds downstream logic in reset until lock has been stable for a qualification window. Runs on the free-running reference clock, never on a PLL output.

---
 rtl/pll_sup_pkg.sv | 20 ++
 rtl/pll_sup_sync.sv | 24 ++
 rtl/pll_lock_supervisor.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/pll_sup_pkg.sv
// Shared types for the PLL lock supervisor: sequencer states, retry counter width,
// and the counter-sizing helper.
package pll_sup_pkg;

    localparam int RETRY_W = 4;

    typedef enum logic [2:0] {
        PLL_RESET = 3'd0,
        WAIT_LOCK = 3'd1,
        STABILIZE = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } sup_state_e;

    // Counters never need fewer than one bit, even for a one-cycle window.
    function automatic int cnt_width(input int n);
        return $clog2((n > 2) ? n : 2);
    endfunction

endpackage

// File: rtl/pll_sup_sync.sv
// Multi-stage bit synchronizer with asynchronous active-low clear, used to bring the
// PLL lock indication into the reference clock domain.
module pll_sup_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer and lock qualifier running on the free-running reference clock.
// Optional macro LOCK_LOSS_COUNT_EN adds the loss_cnt output counting lock losses in RUN.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 100000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3,
    parameter int SYNC_STAGES         = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               pll_locked,
    input  logic               force_relock,
    output logic               pll_rst,
    output logic               sys_reset_n,
    output logic               lock_ok,
    output logic               fail,
    output logic [RETRY_W-1:0] retry_cnt
`ifdef LOCK_LOSS_COUNT_EN
    ,
    output logic [15:0]        loss_cnt
`endif
);

    localparam int RST_W = cnt_width(RST_PULSE_CYCLES);
    localparam int TMO_W = cnt_width(LOCK_TIMEOUT_CYCLES);
    localparam int STB_W = cnt_width(LOCK_STABLE_CYCLES);

    localparam logic [RST_W-1:0]   RST_LAST  = RST_W'(RST_PULSE_CYCLES - 1);
    localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [STB_W-1:0]   STB_LAST  = STB_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

    sup_state_e         state, state_nxt;
    logic [RST_W-1:0]   rst_cnt, rst_cnt_nxt;
    logic [TMO_W-1:0]   tmo_cnt, tmo_cnt_nxt;
    logic [STB_W-1:0]   stb_cnt, stb_cnt_nxt;
    logic [RETRY_W-1:0] retry_nxt;
    logic               lk_s;

    pll_sup_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d     (pll_locked),
        .q     (lk_s)
    );

    // Counters default to zero so every state entry starts its window from scratch.
    always_comb begin
        state_nxt   = state;
        rst_cnt_nxt = '0;
        tmo_cnt_nxt = '0;
        stb_cnt_nxt = '0;
        retry_nxt   = retry_cnt;

        if (force_relock) begin
            state_nxt = PLL_RESET;
            retry_nxt = '0;
        end else begin
            case (state)
                PLL_RESET: begin
                    if (rst_cnt == RST_LAST) begin
                        state_nxt = WAIT_LOCK;
                    end else begin
                        rst_cnt_nxt = rst_cnt + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (lk_s) begin
                        state_nxt = STABILIZE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        if (retry_cnt < RETRY_MAX && retry_cnt != '1) begin
                            retry_nxt = retry_cnt + 1'b1;
                            state_nxt = PLL_RESET;
                        end else begin
                            state_nxt = FAIL;
                        end
                    end else begin
                        tmo_cnt_nxt = tmo_cnt + 1'b1;
                    end
                end
                STABILIZE: begin
                    if (!lk_s) begin
                        state_nxt = WAIT_LOCK;
                    end else if (stb_cnt == STB_LAST) begin
                        state_nxt = RUN;
                    end else begin
                        stb_cnt_nxt = stb_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!lk_s) begin
                        state_nxt = PLL_RESET;
                        retry_nxt = '0;
                    end
                end
                FAIL: begin
                    state_nxt = FAIL;
                end
                default: begin
                    state_nxt = PLL_RESET;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= PLL_RESET;
            rst_cnt     <= '0;
            tmo_cnt     <= '0;
            stb_cnt     <= '0;
            retry_cnt   <= '0;
            pll_rst     <= 1'b1;
            sys_reset_n <= 1'b0;
            lock_ok     <= 1'b0;
            fail        <= 1'b0;
        end else begin
            state       <= state_nxt;
            rst_cnt     <= rst_cnt_nxt;
            tmo_cnt     <= tmo_cnt_nxt;
            stb_cnt     <= stb_cnt_nxt;
            retry_cnt   <= retry_nxt;
            pll_rst     <= (state_nxt == PLL_RESET);
            sys_reset_n <= (state_nxt == RUN);
            lock_ok     <= (state_nxt == RUN);
            fail        <= (state_nxt == FAIL);
        end
    end

`ifdef LOCK_LOSS_COUNT_EN
    // Only a genuine lock drop in RUN counts; a forced relock is not a loss.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            loss_cnt <= '0;
        end else if (state == RUN && !force_relock && !lk_s && loss_cnt != 16'hFFFF) begin
            loss_cnt <= loss_cnt + 16'd1;
        end
    end
`endif

endmodule
